// File: rtl/sram_like_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_responder
// Purpose  : Target side of the sram-like data interface. Requests are served
//            from an internal word-organised RAM, and data_ok follows a fixed,
//            programmable number of cycles after acceptance.
// Option   : SRAM_RESP_RAND_DELAY_EN - an LFSR adds random acceptance stalls
//            and 0..3 extra response cycles.
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [31:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   word_idx;
  logic [3:0]              be;
  logic                    accept;
  logic                    grant;
  logic [1:0]              extra;
  logic [4:0]              lat_total;
  logic                    unused_addr;

`ifdef SRAM_RESP_RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11; free-running every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign grant = lfsr_q[0];
  assign extra = lfsr_q[2:1];
`else
  assign grant = 1'b1;
  assign extra = 2'b00;
`endif

  // Upper address bits only alias the RAM; they are intentionally ignored.
  assign unused_addr = ^addr[31:DEPTH_LOG2+2];

  assign word_idx  = addr[DEPTH_LOG2+1:2];
  assign addr_ok   = (state_q == IDLE) && req && grant;
  assign accept    = addr_ok;
  assign lat_total = 5'(LATENCY) + {3'b000, extra};
  assign data_ok   = (state_q == RESP);
  assign rdata     = rdata_q;

  // Byte-lane enables for writes from size and the low address bits.
  always_comb begin
    be = 4'b1111;
    case (size)
      2'b00:   be = 4'b0001 << addr[1:0];
      2'b01:   be = addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Next-state logic: the access itself happens at acceptance, so the
  // remaining states only count down to the response pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!wr) rdata_d = mem[word_idx];
          if (lat_total == 5'd1) begin
            state_d = RESP;
            cnt_d   = 5'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = lat_total - 5'd1;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 5'd1) begin
          state_d = RESP;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and read-data registers; reset drops any pending response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Backing RAM write port; contents are never cleared by reset.
  always_ff @(posedge clock) begin
    if (accept && wr && !reset) begin
      for (int n = 0; n < 4; n++) begin
        if (be[n]) mem[word_idx][8*n +: 8] <= wdata[8*n +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_responder
// Purpose  : Directed vector bench for sram_like_responder at LATENCY 1, 3, 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_like_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req1 = 1'b0, req3 = 1'b0, req4 = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        addr_ok1, addr_ok3, addr_ok4;
  logic        data_ok1, data_ok3, data_ok4;
  logic [31:0] rdata1, rdata3, rdata4;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sram_like_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset), .req(req1), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok1), .data_ok(data_ok1),
    .rdata(rdata1));

  sram_like_responder #(.DEPTH_LOG2(10), .LATENCY(3)) u_dut3 (
    .clock(clock), .reset(reset), .req(req3), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok3), .data_ok(data_ok3),
    .rdata(rdata3));

  sram_like_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u_dut4 (
    .clock(clock), .reset(reset), .req(req4), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok4), .data_ok(data_ok4),
    .rdata(rdata4));

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // wr, size, addr, wdata, rdata expected in the data_ok cycle
    vecs[0]  = '{1'b1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1]  = '{1'b0, 2'b10, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 2'b10, 32'h0000_0020, 32'h1122_3344, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 2'b00, 32'h0000_0021, 32'hAAAA_AAAA, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 2'b01, 32'h0000_0022, 32'h5555_5555, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 2'b10, 32'h0000_0020, 32'h0000_0000, 32'h5555_AA44};
    vecs[6]  = '{1'b1, 2'b10, 32'h0000_1004, 32'h0BAD_F00D, 32'h5555_AA44};
    vecs[7]  = '{1'b0, 2'b10, 32'h0000_0004, 32'h0000_0000, 32'h0BAD_F00D};
    vecs[8]  = '{1'b1, 2'b00, 32'h0000_0013, 32'h7777_7777, 32'h0BAD_F00D};
    vecs[9]  = '{1'b0, 2'b11, 32'h0000_0010, 32'h0000_0000, 32'h77AD_BEEF};
    vecs[10] = '{1'b1, 2'b01, 32'h0000_0011, 32'h9999_9999, 32'h77AD_BEEF};
    vecs[11] = '{1'b0, 2'b10, 32'h0000_0012, 32'h0000_0000, 32'h77AD_9999};

    // Reset asserted mid-cycle clears outputs immediately.
    #2 reset = 1'b1;
    #1;
    chk("reset_data_ok", {31'b0, data_ok1}, 32'h0);
    chk("reset_addr_ok", {31'b0, addr_ok1}, 32'h0);
    chk("reset_rdata", rdata1, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock); #1;
      chk("idle_data_ok", {31'b0, data_ok1}, 32'h0);
      chk("idle_addr_ok", {31'b0, addr_ok1}, 32'h0);
      chk("idle_rdata", rdata1, 32'h0);
    end

    // LATENCY=1 vector table: accept, then one-cycle data_ok pulse.
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      req1 = 1'b1; wr = vecs[i].wr; size = vecs[i].size;
      addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d_addr_ok", i), {31'b0, addr_ok1}, 32'h1);
      chk($sformatf("v%0d_data_ok_early", i), {31'b0, data_ok1}, 32'h0);
      @(negedge clock);
      req1 = 1'b0;
      #1;
      chk($sformatf("v%0d_data_ok", i), {31'b0, data_ok1}, 32'h1);
      chk($sformatf("v%0d_rdata", i), rdata1, vecs[i].exp_rdata);
      chk($sformatf("v%0d_addr_ok_resp", i), {31'b0, addr_ok1}, 32'h0);
      @(negedge clock); #1;
      chk($sformatf("v%0d_data_ok_pulse", i), {31'b0, data_ok1}, 32'h0);
    end

    // LATENCY=4 with req held high: accepts at 0,5,10; data_ok at 4,9,14.
    @(negedge clock);
    req4 = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h0000_0010;
    #1;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("l4_c%0d_addr_ok", k), {31'b0, addr_ok4},
          (k == 0 || k == 5 || k == 10) ? 32'h1 : 32'h0);
      chk($sformatf("l4_c%0d_data_ok", k), {31'b0, data_ok4},
          (k == 4 || k == 9 || k == 14) ? 32'h1 : 32'h0);
      @(negedge clock); #1;
    end
    req4 = 1'b0;
    repeat (6) @(negedge clock);

    // LATENCY=3: reset during WAIT drops the response but keeps the write.
    req3 = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h0000_0040; wdata = 32'h1234_5678;
    #1;
    chk("l3_wr_addr_ok", {31'b0, addr_ok3}, 32'h1);
    @(negedge clock);
    req3 = 1'b0;
    #1 reset = 1'b1;
    chk("l3_rst_data_ok0", {31'b0, data_ok3}, 32'h0);
    repeat (2) begin
      @(negedge clock); #1;
      chk("l3_rst_data_ok", {31'b0, data_ok3}, 32'h0);
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock); #1;
      chk("l3_post_rst_data_ok", {31'b0, data_ok3}, 32'h0);
    end
    @(negedge clock);
    req3 = 1'b1; wr = 1'b0; addr = 32'h0000_0040;
    #1;
    chk("l3_rd_addr_ok", {31'b0, addr_ok3}, 32'h1);
    @(negedge clock);
    req3 = 1'b0;
    #1;
    chk("l3_rd_t1_data_ok", {31'b0, data_ok3}, 32'h0);
    @(negedge clock); #1;
    chk("l3_rd_t2_data_ok", {31'b0, data_ok3}, 32'h0);
    @(negedge clock); #1;
    chk("l3_rd_t3_data_ok", {31'b0, data_ok3}, 32'h1);
    chk("l3_rd_rdata", rdata3, 32'h1234_5678);
    @(negedge clock); #1;
    chk("l3_rd_t4_data_ok", {31'b0, data_ok3}, 32'h0);
    chk("l3_rd_rdata_hold", rdata3, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
